// File: rtl/nios_multi_timer.sv
// nios_multi_timer: multi-channel Avalon-MM interval timer for the Nios data master.
// Each channel is an independent down-counter with its own period, prescaler,
// one-shot/continuous mode, snapshot register and interrupt enable.
// Register map per channel (address[1:0]):
//   0 STATUS  rd {30'b0, RUN, TO}, any write clears TO
//   1 CONTROL rd {16'b0, PRESC, 6'b0, CONT, ITO}; wr bit2 START / bit3 STOP are pulses
//   2 PERIOD  rd/wr, the next cycle reloads the counter and stops the channel
//   3 SNAP    any write captures the live counter, read returns the capture
// Timeout is the rising edge of a registered (count == 0) compare, so TO rises
// one clock after the counter reaches zero.
module nios_multi_timer #(
  parameter int  NUM_CH     = 2,
  parameter int  CNT_W      = 32,
  parameter int  PRESC_W    = 8,
  parameter int  RST_PERIOD = 49999,
  localparam int ADDR_W     = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic [ADDR_W-1:0] address,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_CONTROL = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_SNAP    = 2'd3;

  localparam logic [CNT_W-1:0]   RST_CNT  = CNT_W'(RST_PERIOD);
  localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [PRESC_W-1:0] PSC_ZERO = {PRESC_W{1'b0}};
  localparam logic [PRESC_W-1:0] PSC_ONE  = PRESC_W'(1);

  // Bus decode shared by all channels
  logic [31:0]             addr_ext_s;
  logic [31:0]             ch_sel_s;
  logic                    ch_valid_s;
  logic [IDX_W-1:0]        ch_idx_s;
  logic [1:0]              reg_sel_s;
  logic                    bus_wr_s;

  logic [NUM_CH-1:0][31:0] rd_words_s;
  logic [NUM_CH-1:0]       irq_vec_s;
  logic [31:0]             readdata_d;
  logic [31:0]             readdata_q;

  assign addr_ext_s = 32'(address);
  assign ch_sel_s   = addr_ext_s >> 2;
  assign ch_valid_s = (ch_sel_s < 32'(NUM_CH));
  assign ch_idx_s   = ch_sel_s[IDX_W-1:0];
  assign reg_sel_s  = address[1:0];
  assign bus_wr_s   = chipselect & ~write_n;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [CNT_W-1:0]   period_q;
    logic [CNT_W-1:0]   snap_q;
    logic [PRESC_W-1:0] psc_q;
    logic [PRESC_W-1:0] psc_d;
    logic [PRESC_W-1:0] presc_q;
    logic               ito_q;
    logic               cont_q;
    logic               run_q;
    logic               run_d;
    logic               to_q;
    logic               to_d;
    logic               zero_q;
    logic               reload_q;

    logic               sel_s;
    logic               status_wr_s;
    logic               ctrl_wr_s;
    logic               period_wr_s;
    logic               snap_wr_s;
    logic               start_s;
    logic               stop_s;
    logic               cnt_zero_s;
    logic               tick_s;
    logic               to_event_s;
    logic [31:0]        rd_word_s;

    assign sel_s       = bus_wr_s && (ch_sel_s == 32'(c));
    assign status_wr_s = sel_s && (reg_sel_s == REG_STATUS);
    assign ctrl_wr_s   = sel_s && (reg_sel_s == REG_CONTROL);
    assign period_wr_s = sel_s && (reg_sel_s == REG_PERIOD);
    assign snap_wr_s   = sel_s && (reg_sel_s == REG_SNAP);
    assign start_s     = ctrl_wr_s && writedata[2];
    assign stop_s      = ctrl_wr_s && writedata[3];

    assign cnt_zero_s  = (count_q == CNT_ZERO);
    assign tick_s      = run_q && (psc_q == presc_q);
    // Rising edge of the registered zero compare, as in the legacy timer
    assign to_event_s  = cnt_zero_s && !zero_q;

    // Next counter, prescaler and RUN; a pending reload overrides counting
    always_comb begin
      count_d = count_q;
      psc_d   = psc_q;
      run_d   = run_q;

      if (reload_q) begin
        count_d = period_q;
      end else if (tick_s) begin
        if (cnt_zero_s) begin
          count_d = period_q;
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end else begin
        count_d = count_q;
      end

      if (start_s || reload_q) begin
        psc_d = PSC_ZERO;
      end else if (run_q) begin
        if (tick_s) begin
          psc_d = PSC_ZERO;
        end else begin
          psc_d = psc_q + PSC_ONE;
        end
      end else begin
        psc_d = psc_q;
      end

      // START beats STOP and reload; one-shot stops on the tick that lands on zero
      if (start_s) begin
        run_d = 1'b1;
      end else if (stop_s || reload_q) begin
        run_d = 1'b0;
      end else if (tick_s && !cont_q && (count_d == CNT_ZERO)) begin
        run_d = 1'b0;
      end else begin
        run_d = run_q;
      end
    end

    // Timeout flag: a STATUS write in the same cycle as an event leaves TO clear
    always_comb begin
      to_d = to_q;
      if (status_wr_s) begin
        to_d = 1'b0;
      end else if (to_event_s) begin
        to_d = 1'b1;
      end else begin
        to_d = to_q;
      end
    end

    // Channel state registers with bus-written configuration
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        count_q  <= RST_CNT;
        period_q <= RST_CNT;
        snap_q   <= CNT_ZERO;
        psc_q    <= PSC_ZERO;
        presc_q  <= PSC_ZERO;
        ito_q    <= 1'b0;
        cont_q   <= 1'b0;
        run_q    <= 1'b0;
        to_q     <= 1'b0;
        zero_q   <= (RST_CNT == CNT_ZERO);
        reload_q <= 1'b0;
      end else begin
        count_q  <= count_d;
        psc_q    <= psc_d;
        run_q    <= run_d;
        to_q     <= to_d;
        zero_q   <= cnt_zero_s;
        reload_q <= period_wr_s;
        if (ctrl_wr_s) begin
          ito_q   <= writedata[0];
          cont_q  <= writedata[1];
          presc_q <= writedata[8 +: PRESC_W];
        end
        if (period_wr_s) begin
          period_q <= writedata[CNT_W-1:0];
        end
        if (snap_wr_s) begin
          snap_q <= count_q;
        end
      end
    end

    // Channel read word, zero-extended to the bus width
    always_comb begin
      case (reg_sel_s)
        REG_STATUS:  rd_word_s = {30'd0, run_q, to_q};
        REG_CONTROL: rd_word_s = {16'd0, 8'(presc_q), 6'd0, cont_q, ito_q};
        REG_PERIOD:  rd_word_s = 32'(period_q);
        REG_SNAP:    rd_word_s = 32'(snap_q);
        default:     rd_word_s = 32'd0;
      endcase
    end

    assign rd_words_s[c] = rd_word_s;
    assign irq_vec_s[c]  = to_q & ito_q;
  end

  // Address mux; unpopulated channel slots read as zero
  always_comb begin
    readdata_d = 32'd0;
    if (ch_valid_s) begin
      readdata_d = rd_words_s[ch_idx_s];
    end else begin
      readdata_d = 32'd0;
    end
  end

  // Read data is refreshed every clock, independent of chipselect
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata_q <= 32'd0;
    end else begin
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq_vec  = irq_vec_s;
  assign irq      = |irq_vec_s;

endmodule

// File: tb/tb_nios_multi_timer.sv
// Testbench for nios_multi_timer: per-feature tasks with randomized periods and
// prescalers, expected timing derived from the period/prescaler arithmetic.
module tb_nios_multi_timer;
  localparam int NUM_CH     = 3;
  localparam int RST_PERIOD = 49999;
  localparam int ADDR_W     = $clog2(NUM_CH) + 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              chipselect;
  logic [ADDR_W-1:0] address;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] irq_vec;
  logic              irq;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  nios_multi_timer #(.NUM_CH(NUM_CH)) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq_vec(irq_vec), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // All drives and samples happen 1 ns after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) idle(1);
  endtask

  task automatic bus_write(input int ch, input int rg, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0;
    address = ADDR_W'((ch << 2) | rg);
    writedata = d;
    idle(1);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  // Returns the register contents as they were when the task was entered.
  task automatic bus_read(input int ch, input int rg, output logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b1;
    address = ADDR_W'((ch << 2) | rg);
    idle(1);
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    idle(2);
    reset_n = 1'b1;
  endtask

  // Cycle number at which irq_vec[ch] is first seen high, -1 if budget expires.
  task automatic wait_rise(input int ch, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (irq_vec[ch] === 1'b1) begin
        at = cyc;
        break;
      end
      idle(1);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    address = ADDR_W'(2);
    idle(2);
    n_cmp++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL reset_readdata: got %0d want 0", readdata); end
    n_cmp++; if (irq_vec !== 3'b000 || irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got vec=%b irq=%b want 0", irq_vec, irq); end
    reset_n = 1'b1;
    bus_read(0, 2, rd);
    n_cmp++; if (rd !== 32'(RST_PERIOD)) begin n_bad++; $display("FAIL reset_period: got %0d want %0d", rd, RST_PERIOD); end
    bus_read(0, 0, rd);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL reset_status: got %0d want 0", rd); end
    bus_read(1, 1, rd);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL reset_control: got %0d want 0", rd); end
    bus_read(2, 3, rd);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL reset_snap: got %0d want 0", rd); end
    // Reset in the middle of a count
    bus_write(0, 1, 32'h4);
    idle(20);
    bus_read(0, 0, rd);
    n_cmp++; if (rd !== 32'd2) begin n_bad++; $display("FAIL midreset_running: got %0d want 2", rd); end
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    bus_read(0, 0, rd);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL midreset_status: got %0d want 0", rd); end
    bus_write(0, 3, 32'd0);
    bus_read(0, 3, rd);
    n_cmp++; if (rd !== 32'(RST_PERIOD)) begin n_bad++; $display("FAIL midreset_count: got %0d want %0d", rd, RST_PERIOD); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL midreset_irq: got %b want 0", irq); end
  endtask

  task automatic test_oneshot();
    logic [31:0] rd;
    int p, q, s, at, exp_at;
    for (int it = 0; it < 3; it++) begin
      p = (it == 0) ? 5 : int'($urandom_range(2, 12));
      q = (it == 0) ? 0 : int'($urandom_range(0, 3));
      do_reset();
      bus_write(0, 2, 32'(p));
      bus_write(0, 1, 32'((q << 8) | 5));
      s = cyc;
      exp_at = s + p * (q + 1) + 1;
      wait_rise(0, p * (q + 1) + 20, at);
      n_cmp++; if (at !== exp_at) begin n_bad++; $display("FAIL oneshot_to_time: got cycle %0d want %0d (P=%0d Q=%0d)", at, exp_at, p, q); end
      n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL oneshot_irq: got %b want 1", irq); end
      bus_read(0, 0, rd);
      n_cmp++; if (rd !== 32'd1) begin n_bad++; $display("FAIL oneshot_status: got %0d want 1", rd); end
      bus_read(0, 1, rd);
      n_cmp++; if (rd !== 32'((q << 8) | 1)) begin n_bad++; $display("FAIL oneshot_control: got %h want %h", rd, 32'((q << 8) | 1)); end
      idle(5);
      bus_write(0, 3, 32'd0);
      bus_read(0, 3, rd);
      n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL oneshot_hold: got %0d want 0", rd); end
      // Restart from zero: the first tick reloads PERIOD
      bus_write(0, 0, 32'd0);
      n_cmp++; if (irq_vec[0] !== 1'b0) begin n_bad++; $display("FAIL oneshot_clear: got %b want 0", irq_vec[0]); end
      bus_write(0, 1, 32'((q << 8) | 5));
      s = cyc;
      exp_at = s + (p + 1) * (q + 1) + 1;
      wait_rise(0, (p + 1) * (q + 1) + 20, at);
      n_cmp++; if (at !== exp_at) begin n_bad++; $display("FAIL oneshot_restart_time: got cycle %0d want %0d", at, exp_at); end
    end
  endtask

  task automatic test_continuous();
    logic [31:0] rd;
    int p, q, len, s, at, e1, e2, e3, e4;
    for (int it = 0; it < 3; it++) begin
      p = (it == 0) ? 3 : int'($urandom_range(2, 6));
      q = (it == 0) ? 1 : int'($urandom_range(1, 3));
      len = (p + 1) * (q + 1);
      do_reset();
      bus_write(0, 2, 32'(p));
      bus_write(0, 1, 32'((q << 8) | 7));
      s = cyc;
      e1 = s + p * (q + 1) + 1;
      wait_rise(0, len + 20, at);
      n_cmp++; if (at !== e1) begin n_bad++; $display("FAIL cont_first_to: got cycle %0d want %0d (P=%0d Q=%0d)", at, e1, p, q); end
      bus_write(0, 0, 32'd0);
      n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL cont_clear: got irq %b want 0", irq); end
      e2 = e1 + len;
      wait_rise(0, len + 20, at);
      n_cmp++; if (at !== e2) begin n_bad++; $display("FAIL cont_second_to: got cycle %0d want %0d", at, e2); end
      bus_write(0, 0, 32'd0);
      e3 = e2 + len;
      wait_until(e3 - 1);
      bus_write(0, 0, 32'd0);
      n_cmp++; if (irq_vec[0] !== 1'b0) begin n_bad++; $display("FAIL cont_coincident_clear: got %b want 0", irq_vec[0]); end
      bus_read(0, 0, rd);
      n_cmp++; if (rd !== 32'd2) begin n_bad++; $display("FAIL cont_status_running: got %0d want 2", rd); end
      e4 = e3 + len;
      wait_rise(0, len + 20, at);
      n_cmp++; if (at !== e4) begin n_bad++; $display("FAIL cont_fourth_to: got cycle %0d want %0d", at, e4); end
    end
  endtask

  task automatic test_snapshot();
    logic [31:0] rd;
    int p, w, w2, s, exp_v;
    for (int it = 0; it < 2; it++) begin
      p = (it == 0) ? 1000 : int'($urandom_range(300, 2000));
      w = (it == 0) ? 100 : int'($urandom_range(50, 150));
      do_reset();
      bus_write(0, 2, 32'(p));
      bus_write(0, 1, 32'h4);
      s = cyc;
      // SNAP captures the count as it stood one clock before the write edge
      wait_until(s + w - 1);
      bus_write(0, 3, 32'd0);
      exp_v = p - (w - 1);
      bus_read(0, 3, rd);
      n_cmp++; if (rd !== 32'(exp_v)) begin n_bad++; $display("FAIL snap_value: got %0d want %0d (P=%0d wait=%0d)", rd, exp_v, p, w); end
      w2 = w + int'($urandom_range(10, 60));
      wait_until(s + w2 - 1);
      bus_write(0, 3, 32'd0);
      exp_v = p - (w2 - 1);
      bus_read(0, 3, rd);
      n_cmp++; if (rd !== 32'(exp_v)) begin n_bad++; $display("FAIL snap_second: got %0d want %0d", rd, exp_v); end
    end
  endtask

  task automatic test_multichannel();
    logic [31:0] rd;
    int p0, p1, p2, s0, s1, s2, r0, r1, r2, c, nxt, at, bad_or;
    int rise [3];
    p0 = int'($urandom_range(2, 8));
    p1 = int'($urandom_range(3, 12));
    p2 = p0 - 1;
    do_reset();
    bus_write(0, 2, 32'(p0));
    bus_write(1, 2, 32'(p1));
    bus_write(2, 2, 32'(p2));
    bus_write(0, 1, 32'h7); s0 = cyc;
    bus_write(2, 1, 32'h7); s2 = cyc;
    bus_write(1, 1, 32'h7); s1 = cyc;
    r0 = s0 + p0 + 1;
    r1 = s1 + p1 + 1;
    r2 = s2 + p2 + 1;
    for (int k = 0; k < 3; k++) rise[k] = -1;
    bad_or = 0;
    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (irq_vec[k] === 1'b1 && rise[k] < 0) rise[k] = cyc;
      end
      if (irq !== |irq_vec) bad_or++;
      idle(1);
    end
    n_cmp++; if (rise[0] !== r0) begin n_bad++; $display("FAIL multi_ch0_to: got cycle %0d want %0d", rise[0], r0); end
    n_cmp++; if (rise[1] !== r1) begin n_bad++; $display("FAIL multi_ch1_to: got cycle %0d want %0d", rise[1], r1); end
    n_cmp++; if (rise[2] !== r2) begin n_bad++; $display("FAIL multi_ch2_same_cycle: got cycle %0d want %0d", rise[2], r2); end
    n_cmp++; if (bad_or !== 0) begin n_bad++; $display("FAIL multi_irq_or: got %0d bad cycles want 0", bad_or); end
    bus_write(0, 0, 32'd0);
    c = cyc;
    n_cmp++; if (irq_vec !== 3'b110 || irq !== 1'b1) begin n_bad++; $display("FAIL multi_independent_clear: got vec=%b irq=%b want 110/1", irq_vec, irq); end
    nxt = r0 + ((c - r0) / (p0 + 1) + 1) * (p0 + 1);
    wait_rise(0, p0 + 20, at);
    n_cmp++; if (at !== nxt) begin n_bad++; $display("FAIL multi_ch0_wrap: got cycle %0d want %0d", at, nxt); end
    // Channel 3 does not exist with three channels
    bus_write(3, 2, 32'd123);
    bus_read(3, 2, rd);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL oor_period: got %0d want 0", rd); end
    bus_read(3, 1, rd);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL oor_control: got %0d want 0", rd); end
    bus_read(1, 2, rd);
    n_cmp++; if (rd !== 32'(p1)) begin n_bad++; $display("FAIL oor_no_alias: got %0d want %0d", rd, p1); end
  endtask

  task automatic test_collisions();
    logic [31:0] rd;
    int np;
    do_reset();
    bus_write(0, 2, 32'd50);
    bus_write(0, 1, 32'hC);
    bus_read(0, 0, rd);
    n_cmp++; if (rd !== 32'd2) begin n_bad++; $display("FAIL coll_start_stop: got %0d want 2", rd); end
    bus_write(0, 1, 32'h8);
    bus_read(0, 0, rd);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL coll_stop: got %0d want 0", rd); end
    bus_write(0, 1, 32'h4);
    idle(3);
    np = int'($urandom_range(10, 500));
    bus_write(0, 2, 32'(np));
    idle(1);
    bus_write(0, 3, 32'd0);
    bus_read(0, 3, rd);
    n_cmp++; if (rd !== 32'(np)) begin n_bad++; $display("FAIL coll_reload_count: got %0d want %0d", rd, np); end
    bus_read(0, 0, rd);
    n_cmp++; if (rd !== 32'd0) begin n_bad++; $display("FAIL coll_reload_stops: got %0d want 0", rd); end
    idle(5);
    bus_write(0, 3, 32'd0);
    bus_read(0, 3, rd);
    n_cmp++; if (rd !== 32'(np)) begin n_bad++; $display("FAIL coll_count_held: got %0d want %0d", rd, np); end
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = '0; writedata = 32'd0;
    idle(1);
    test_reset();
    test_oneshot();
    test_continuous();
    test_snapshot();
    test_multichannel();
    test_collisions();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
